// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared state type and default sizing for adder_arbiter
package adder_arbiter_pkg;
    typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NUM_REQ = 4;
endpackage

// File: rtl/adder.sv
// adder: combinational modulo-2^WIDTH adder shared by the arbitrated requesters
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, wrapping at N-1
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_NUM_REQ,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);
    logic [PW-1:0] w_idx;
    // Walk offsets from farthest to nearest so the closest request after ptr wins.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = PW'((int'(ptr) + i) % N);
            if (req[w_idx]) begin
                grant_idx = w_idx;
                any_grant = 1'b1;
            end
        end
    end
    assign grant_onehot = any_grant ? (N'(1) << grant_idx) : '0;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder with a one-entry tagged response buffer.
// Define ADDER_ARBITER_CARRY_EN to add the registered rsp_carry output.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
`ifdef ADDER_ARBITER_CARRY_EN
    output logic                     rsp_carry,
`endif
    output logic [WIDTH-1:0]         rsp_result
);
    arb_state_t r_state, w_next;
    logic [ID_W-1:0] r_ptr, r_id, w_gidx;
    logic [NUM_REQ-1:0] w_onehot;
    logic w_any, w_can_accept, w_xfer;
    logic [WIDTH-1:0] w_a, w_b, r_result;

    rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_rr (
        .req(req_valid),
        .ptr(r_ptr),
        .grant_onehot(w_onehot),
        .grant_idx(w_gidx),
        .any_grant(w_any)
    );

    // Draining the buffer this cycle frees it for a same-cycle refill.
    assign w_can_accept = (r_state == ARB_EMPTY) | rsp_ready;
    assign w_xfer = w_any & w_can_accept & ~rst;
    assign req_ready = w_xfer ? w_onehot : '0;
    assign w_a = req_a[int'(w_gidx) * WIDTH +: WIDTH];
    assign w_b = req_b[int'(w_gidx) * WIDTH +: WIDTH];

`ifdef ADDER_ARBITER_CARRY_EN
    logic [WIDTH:0] w_sum;
    logic r_carry;
    adder #(.WIDTH(WIDTH + 1)) u_adder (.i_a({1'b0, w_a}), .i_b({1'b0, w_b}), .o_sum(w_sum));
    always_ff @(posedge clk) begin
        if (rst) r_carry <= 1'b0;
        else if (w_xfer) r_carry <= w_sum[WIDTH];
    end
    assign rsp_carry = r_carry;
`else
    logic [WIDTH-1:0] w_sum;
    adder #(.WIDTH(WIDTH)) u_adder (.i_a(w_a), .i_b(w_b), .o_sum(w_sum));
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ARB_EMPTY;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = w_xfer ? ARB_FULL : ((r_state == ARB_FULL && rsp_ready) ? ARB_EMPTY : r_state);
    end

    always_comb begin
        rsp_valid = (r_state == ARB_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_id <= '0;
            r_result <= '0;
        end else if (w_xfer) begin
            r_ptr <= ID_W'((int'(w_gidx) + 1) % NUM_REQ);
            r_id <= w_gidx;
            r_result <= w_sum[WIDTH-1:0];
        end
    end

    assign rsp_id = r_id;
    assign rsp_result = r_result;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench with a queue-based reference model for adder_arbiter
module tb_adder_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rsp_ready = 1'b0;
    logic [N-1:0] req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic rsp_valid;
    logic [1:0] rsp_id;
    logic [W-1:0] rsp_result;
`ifdef ADDER_ARBITER_CARRY_EN
    logic rsp_carry;
`endif

    typedef struct {
        logic [1:0] id;
        logic [W-1:0] res;
        logic c;
    } exp_t;
    exp_t q[$];

    logic [W-1:0] op_a[N];
    logic [W-1:0] op_b[N];
    bit pend[N];
    bit m_full = 0;
    int m_ptr = 0;
    int checks = 0;
    int failures = 0;

    adder_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
`ifdef ADDER_ARBITER_CARRY_EN
        .rsp_carry(rsp_carry),
`endif
        .rsp_result(rsp_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: apply rst/rsp_ready, predict grant from the fairness rule, advance the model.
    task automatic step(input bit r, input bit rr);
        int g, s;
        bit found, can;
        logic [N-1:0] exp_rdy;
        rst = r;
        rsp_ready = rr;
        #1;
        can = !m_full || rr;
        found = 0;
        g = 0;
        for (int k = 0; k < N; k++)
            if (!found && pend[(m_ptr + k) % N]) begin
                found = 1;
                g = (m_ptr + k) % N;
            end
        exp_rdy = (!r && can && found) ? N'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (r) begin
            q.delete();
            m_full = 0;
            m_ptr = 0;
        end else if (exp_rdy != '0) begin
            s = int'(op_a[g]) + int'(op_b[g]);
            q.push_back('{id: 2'(g), res: W'(s), c: (s > 255)});
            m_full = 1;
            m_ptr = (g + 1) % N;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        if (!r && exp_rdy != '0) pend[g] = 0;
    endtask

    task automatic set_pend(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) pend[i] = v[i];
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d result=%0h expected no response", rsp_id, rsp_result);
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_result", 32'(rsp_result), 32'(q[0].res));
`ifdef ADDER_ARBITER_CARRY_EN
                check("rsp_carry", 32'(rsp_carry), 32'(q[0].c));
`endif
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(i + 3);
            op_b[i] = 8'h20;
        end
        set_pend(4'b1111);
        @(posedge clk);
        #1;
        step(1, 1);
        step(1, 1);
        check("reset_id", 32'(rsp_id), 32'h0);
        check("reset_result", 32'(rsp_result), 32'h0);
        step(0, 1);
        check("first_grant_id", 32'(rsp_id), 32'h0);
        set_pend(4'b0000);
        step(0, 1);

        op_a[1] = 8'h12;
        op_b[1] = 8'h34;
        set_pend(4'b0010);
        step(0, 1);
        check("single_result", 32'(rsp_result), 32'h46);
        step(0, 1);

        step(1, 1);
        for (int i = 0; i < N; i++) begin
            op_a[i] = W'(i);
            op_b[i] = 8'h10;
        end
        for (int c = 0; c < 8; c++) begin
            set_pend(4'b1111);
            step(0, 1);
        end
        set_pend(4'b0000);
        step(0, 1);

        op_a[2] = 8'h40;
        op_b[2] = 8'h06;
        set_pend(4'b0100);
        step(0, 1);
        op_a[0] = 8'h01;
        op_a[3] = 8'h05;
        op_b[3] = 8'h07;
        set_pend(4'b1001);
        for (int c = 0; c < 3; c++) begin
            step(0, 0);
            check("held_id", 32'(rsp_id), 32'h2);
            check("held_result", 32'(rsp_result), 32'h46);
        end
        step(0, 1);
        check("bp_next_id", 32'(rsp_id), 32'h3);
        set_pend(4'b0000);
        step(0, 1);
        step(0, 1);

        op_a[0] = 8'hFF;
        op_b[0] = 8'h01;
        set_pend(4'b0001);
        step(0, 1);
        check("wrap_result", 32'(rsp_result), 32'h00);
        op_a[0] = 8'h7F;
        set_pend(4'b0001);
        step(0, 1);
        check("half_result", 32'(rsp_result), 32'h80);
        step(0, 1);

        set_pend(4'b0010);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        check("midreset_valid", 32'(rsp_valid), 32'h0);
        set_pend(4'b0100);
        step(0, 1);
        check("post_reset_id", 32'(rsp_id), 32'h2);
        set_pend(4'b1111);
        step(0, 1);
        check("post_reset_ptr", 32'(rsp_id), 32'h3);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    op_a[i] = W'($urandom);
                    op_b[i] = W'($urandom);
                end
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
        end
        set_pend(4'b0000);
        for (int c = 0; c < 3; c++) step(0, 1);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares one combinational `adder` instance between NUM_REQ requesters using round-robin arbitration. Each requester uses a valid/ready request handshake. The block registers the sum in a one-entry response buffer, tagged with the granted requester's id. It sits between CPU-side operand producers (e.g. PC increment, address generation, ALU) and the single adder.

Parameters:
- WIDTH, 8, operand and result width in bits
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of the requester id (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same slicing as req_a
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  ID_W  requester index that produced the result
- rsp_result  out  WIDTH  registered sum, modulo 2^WIDTH

Behaviour:
- State machine:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Reset (rst=1 at a clock edge, valid in any state, including mid-transfer):
  - State becomes EMPTY and the rr pointer becomes 0.
  - rsp_id and rsp_result become 0.
  - The pending response is discarded; nothing is replayed.
  - While rst=1, req_ready=0.
- can_accept = (state==EMPTY) | rsp_ready. This is the same-cycle bypass when the response is drained.
- Arbitration (combinational):
  - Search req_valid from index ptr upward, wrapping at NUM_REQ-1 to 0.
  - The first set bit is the grant g.
  - req_ready[g]=1 only when can_accept and rst=0; all other req_ready bits are 0.
  - If no request is valid, req_ready=0.
- Transfer: requester g completes when req_valid[g] & req_ready[g]. On that edge:
  - rsp_result <= a_g + b_g, computed by the instantiated adder; carry-out is dropped.
  - rsp_id <= g.
  - State becomes FULL.
  - ptr <= (g+1) mod NUM_REQ.
- ptr changes only on a transfer. With no grants it holds, so there is no starvation.
- Response:
  - If rsp_valid & rsp_ready and there is no new transfer, state becomes EMPTY.
  - If both happen on the same edge, the buffer is overwritten with the new result and stays FULL.
- While FULL and rsp_ready=0, rsp_id and rsp_result hold stable and all req_ready are 0.
- Latency: a transfer at edge N gives rsp_valid=1 after edge N. Sustained throughput is 1 result/cycle when rsp_ready=1.
- Operand sampling: operands are captured only on the transfer edge. Requesters must hold req_valid and operands stable until accepted. A requester dropping req_valid before acceptance is legal; it is simply not granted.
- No combinational path from rsp_ready to rsp_valid. rsp_ready does reach req_ready combinationally (the bypass above).

Optional Feature:
- Macro: ADDER_ARBITER_CARRY_EN.
- Defined:
  - Adds output port rsp_carry (1 bit), registered with rsp_result.
  - rsp_carry = bit WIDTH of the (WIDTH+1)-bit sum of the zero-extended operands.
  - Reset value 0.
- Undefined: the port is absent and the carry is not computed.

Decomposition:
- Package adder_arbiter_pkg holds:
  - typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t
  - localparam DEFAULT_WIDTH=8
  - localparam DEFAULT_NUM_REQ=4
- Sub-module rr_arbiter (params N):
  - Inputs: req[N], ptr[$clog2(N)].
  - Outputs: grant_onehot[N], grant_idx, any_grant.
  - Purely combinational, reusable.
- The top level instantiates rr_arbiter and the existing `adder`. It holds the state, ptr and response registers.

Test Plan (WIDTH=8, NUM_REQ=4):
1. Reset: hold rst=1 for 2 cycles with all req_valid=1.
   -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0.
   -> After release, the first grant goes to requester 0.
2. Single request: req_valid=4'b0010, a1=8'h12, b1=8'h34, rsp_ready=1.
   -> req_ready=4'b0010 in the same cycle.
   -> Next cycle rsp_valid=1, rsp_id=1, rsp_result=8'h46.
3. Fairness: req_valid=4'b1111 held for 8 cycles with rsp_ready=1 and a_i=i, b_i=8'h10.
   -> rsp_id sequence is 0,1,2,3,0,1,2,3.
   -> Results are 8'h10, 8'h11, 8'h12, 8'h13, repeating.
4. Backpressure: with FULL (id=2, result=8'h46), set rsp_ready=0 for 3 cycles with req_valid=4'b1001.
   -> req_ready=0 and the response is held stable.
   -> When rsp_ready=1, requester 3 is granted in that same cycle, and the next response has rsp_id=3.
5. Wrap-around: a0=8'hFF, b0=8'h01.
   -> rsp_result=8'h00.
   -> With ADDER_ARBITER_CARRY_EN, rsp_carry=1; a0=8'h7F, b0=8'h01 gives 8'h80 with carry 0.
6. Reset mid-operation: assert rst while FULL and rsp_ready=0.
   -> Next cycle rsp_valid=0 and the pending result is lost.
   -> After release with req_valid=4'b0100, the grant goes to 2 and ptr becomes 3.
